// File: rtl/exu_muldiv_seq_if.sv
// Request/response bundle between the dispatch side, the mul/div sequencer and writeback.
// Signal names keep the i_/o_ direction prefixes as seen from the sequencer.
interface exu_muldiv_seq_if #(parameter int XLEN = 64);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic            i_word;
  logic [XLEN-1:0] i_src1;
  logic [XLEN-1:0] i_src2;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_res;
  logic            o_busy;

  modport master (output i_valid, i_op, i_word, i_src1, i_src2, i_flush, i_ready,
                  input  o_ready, o_valid, o_res, o_busy);
  modport slave  (input  i_valid, i_op, i_word, i_src1, i_src2, i_flush, i_ready,
                  output o_ready, o_valid, o_res, o_busy);
endinterface

// File: rtl/exu_muldiv_seq.sv
// RV64M iterative multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// with sign fix-up in a dedicated cycle and divide special cases resolved at accept.
module exu_muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input logic             clk,
  input logic             rst,
  exu_muldiv_seq_if.slave io
);
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  // acc: product (mul) or partial remainder (div); mcd: shifting multiplicand or divisor
  logic [2*XLEN-1:0] acc, mcd;
  // opd: multiplier shifting right (mul) or dividend turning into quotient (div)
  logic [XLEN-1:0]   opd;
  logic              word_q, div_q, hi_q, rem_q, negq_q, negr_q;
  logic              ready_q, valid_q, busy_q;
  logic [XLEN-1:0]   res_q;

  // accept-time operand preparation
  logic [2:0]      op_e;
  logic            zx, s1, s2, neg1, neg2, ovf, special;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, dmin, raw, spec_res;

  always_comb begin
    op_e = (io.i_word && !io.i_op[2]) ? OP_MUL : io.i_op;
    zx   = (op_e == OP_DIVU) || (op_e == OP_REMU);
    s1   = (op_e == OP_MULH) || (op_e == OP_MULHSU) || (op_e == OP_DIV) || (op_e == OP_REM);
    s2   = (op_e == OP_MULH) || (op_e == OP_DIV) || (op_e == OP_REM);
    ext1 = io.i_src1;
    ext2 = io.i_src2;
    if (io.i_word) begin
      ext1 = zx ? {{(XLEN-32){1'b0}}, io.i_src1[31:0]} : sx32(io.i_src1[31:0]);
      ext2 = zx ? {{(XLEN-32){1'b0}}, io.i_src2[31:0]} : sx32(io.i_src2[31:0]);
    end
    neg1    = s1 && ext1[XLEN-1];
    neg2    = s2 && ext2[XLEN-1];
    mag1    = neg1 ? -ext1 : ext1;
    mag2    = neg2 ? -ext2 : ext2;
    dmin    = io.i_word ? sx32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    ovf     = !zx && (ext1 == dmin) && (ext2 == {XLEN{1'b1}});
    special = op_e[2] && ((ext2 == '0) || ovf);
    if (ext2 == '0) raw = op_e[1] ? ext1 : {XLEN{1'b1}};
    else            raw = op_e[1] ? '0 : ext1;
    spec_res = io.i_word ? sx32(raw[31:0]) : raw;
  end

  // one restoring-divide step
  logic [XLEN:0]   rs;
  logic [XLEN-1:0] rsub;
  logic            ge;

  always_comb begin
    rs   = {acc[XLEN-1:0], opd[XLEN-1]};
    ge   = rs >= {1'b0, mcd[XLEN-1:0]};
    rsub = rs[XLEN-1:0] - mcd[XLEN-1:0];
  end

  // sign fix-up and result selection
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, pick, fix_res;

  always_comb begin
    prod = negq_q ? -acc : acc;
    quo  = negq_q ? -opd : opd;
    rmd  = negr_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    if (div_q) pick = rem_q ? rmd : quo;
    else       pick = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    fix_res = word_q ? sx32(pick[31:0]) : pick;
  end

  logic [CNT_W-1:0] last_cnt;
  assign last_cnt = word_q ? CNT_W'(31) : CNT_W'(XLEN-1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcd     <= '0;
      opd     <= '0;
      word_q  <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= 1'b0;
      rem_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= '0;
    end else if (io.i_flush) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.i_valid) begin
          word_q  <= io.i_word;
          div_q   <= op_e[2];
          hi_q    <= op_e != OP_MUL;
          rem_q   <= op_e[1];
          negq_q  <= neg1 ^ neg2;
          negr_q  <= neg1;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          cnt     <= '0;
          acc     <= '0;
          if (op_e[2]) begin
            mcd <= {{XLEN{1'b0}}, mag2};
            // word dividends are pre-aligned so the MSB-first walk starts at bit 31
            opd <= io.i_word ? (mag1 << 32) : mag1;
          end else begin
            mcd <= {{XLEN{1'b0}}, mag1};
            opd <= mag2;
          end
          if (special) begin
            res_q   <= spec_res;
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            state   <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (div_q) begin
            acc <= {{XLEN{1'b0}}, ge ? rsub : rs[XLEN-1:0]};
            opd <= {opd[XLEN-2:0], ge};
          end else begin
            if (opd[0]) acc <= acc + mcd;
            mcd <= mcd << 1;
            opd <= opd >> 1;
          end
          if (cnt == last_cnt) state <= FIX;
        end
        FIX: begin
          res_q   <= fix_res;
          valid_q <= 1'b1;
          state   <= DONE;
        end
        DONE: if (io.i_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.o_ready = ready_q;
  assign io.o_valid = valid_q;
  assign io.o_busy  = busy_q;
  assign io.o_res   = res_q;
endmodule

// File: tb/tb_exu_muldiv_seq.sv
// Bench for exu_muldiv_seq: directed vector table, randomized ops against an arithmetic
// reference model, and hand sequences for backpressure, flush and async reset.
module tb_exu_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exu_muldiv_seq_if #(.XLEN(64)) bus();
  exu_muldiv_seq #(.XLEN(64), .CNT_W(7)) dut (.clk(clk), .rst(rst), .io(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: plain wide arithmetic. lat counts clock edges after the accept edge until
  // o_valid is seen high (0 = already high in the cycle right after accept).
  task automatic model(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output int lat);
    logic [127:0] p;
    logic [31:0]  ua, ub, t;
    longint       sa, sb;
    int           wa, wb;
    lat = w ? 33 : 65;
    r   = '0;
    if (w) begin
      ua = a[31:0]; ub = b[31:0]; wa = ua; wb = ub;
      case (op)
        3'd4: if (ub == 0) begin r = '1; lat = 0; end
              else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin r = sx32(ua); lat = 0; end
              else begin t = wa / wb; r = sx32(t); end
        3'd5: if (ub == 0) begin r = '1; lat = 0; end
              else begin t = ua / ub; r = sx32(t); end
        3'd6: if (ub == 0) begin r = sx32(ua); lat = 0; end
              else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin r = '0; lat = 0; end
              else begin t = wa % wb; r = sx32(t); end
        3'd7: if (ub == 0) begin r = sx32(ua); lat = 0; end
              else begin t = ua % ub; r = sx32(t); end
        default: begin t = ua * ub; r = sx32(t); end
      endcase
    end else begin
      sa = a; sb = b;
      case (op)
        3'd0: r = a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
        3'd4: if (b == 0) begin r = '1; lat = 0; end
              else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = a; lat = 0; end
              else r = sa / sb;
        3'd5: if (b == 0) begin r = '1; lat = 0; end
              else r = a / b;
        3'd6: if (b == 0) begin r = a; lat = 0; end
              else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = '0; lat = 0; end
              else r = sa % sb;
        default: if (b == 0) begin r = a; lat = 0; end
                 else r = a % b;
      endcase
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input int hold, output logic [63:0] res, output int lat);
    logic saw_rdy;
    chk("ready_idle", bus.o_ready, 1);
    bus.i_op = op; bus.i_word = w; bus.i_src1 = a; bus.i_src2 = b; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    lat = 0; saw_rdy = 1'b0;
    while (!bus.o_valid && lat < 200) begin
      if (bus.o_ready) saw_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("ready_low_busy", saw_rdy, 0);
    res = bus.o_res;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.o_valid, 1);
      chk("hold_res", bus.o_res, res);
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    chk("valid_drop", bus.o_valid, 0);
    chk("ready_back", bus.o_ready, 1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a, b, res;
    int          lat;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] res, input int lat);
    vec_t v;
    v.op = op; v.w = w; v.a = a; v.b = b; v.res = res; v.lat = lat;
    tv.push_back(v);
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = 64'($urandom_range(0, 50));
      1: v = 64'd0 - 64'($urandom_range(1, 50));
      2: v = {$urandom, $urandom};
      3: v = '0;
      4: v = '1;
      5: v = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : sx32(32'h8000_0000);
      default: v = {32'd0, $urandom};
    endcase
    return v;
  endfunction

  logic [63:0] got, exp_r;
  int          lat, exp_l;
  logic        saw;

  initial begin
    bus.i_valid = 1'b0; bus.i_op = '0; bus.i_word = 1'b0; bus.i_src1 = '0; bus.i_src2 = '0;
    bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_busy",  bus.o_busy,  0);
    chk("rst_res",   bus.o_res,   0);
    #20;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", bus.o_ready, 1);

    add(3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    add(3'd3, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    add(3'd1, 0, '1, '1, 64'd0, 65);
    add(3'd2, 0, '1, 64'd2, '1, 65);
    add(3'd4, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    add(3'd6, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    add(3'd5, 1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
    add(3'd4, 0, 64'd5, 64'd0, '1, 0);
    add(3'd7, 0, 64'd5, 64'd0, 64'd5, 0);
    add(3'd4, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0);
    add(3'd6, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 0);
    add(3'd4, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0);
    add(3'd0, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    add(3'd6, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 33);
    add(3'd5, 1, 64'h0000_0000_1234_5678, 64'hABCD_0000_0000_0000, '1, 0);
    add(3'd7, 1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 0);
    add(3'd3, 1, 64'd3, 64'd5, 64'd15, 33);

    for (int i = 0; i < tv.size(); i++) begin
      run_op(tv[i].op, tv[i].w, tv[i].a, tv[i].b, (i == 0) ? 10 : 1, got, lat);
      chk($sformatf("vec%0d_res", i), got, tv[i].res);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tv[i].lat));
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic        w;
      logic [63:0] a, b;
      op = 3'($urandom_range(0, 7)); w = 1'($urandom_range(0, 1));
      a = rnd64(); b = rnd64();
      model(op, w, a, b, exp_r, exp_l);
      run_op(op, w, a, b, $urandom_range(0, 2), got, lat);
      chk($sformatf("rnd%0d_op%0d_w%0d_res", i, op, w), got, exp_r);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_l));
    end

    // flush during iteration: nothing may come out, next op is clean
    bus.i_op = 3'd4; bus.i_word = 1'b0; bus.i_src1 = 64'd1000; bus.i_src2 = 64'd7; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("flush_pre_busy", bus.o_busy, 1);
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    chk("flush_busy", bus.o_busy, 0);
    chk("flush_ready", bus.o_ready, 1);
    chk("flush_valid", bus.o_valid, 0);
    saw = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.o_valid) saw = 1'b1;
    end
    chk("flush_no_result", saw, 0);
    run_op(3'd0, 0, 64'd3, 64'd4, 0, got, lat);
    chk("after_flush_mul", got, 64'd12);

    // flush beats the DONE handshake and discards the held result
    bus.i_op = 3'd4; bus.i_word = 1'b0; bus.i_src1 = 64'd9; bus.i_src2 = 64'd0; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    chk("done_valid", bus.o_valid, 1);
    bus.i_flush = 1'b1; bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    chk("done_flush_valid", bus.o_valid, 0);
    chk("done_flush_ready", bus.o_ready, 1);

    // async reset mid-iteration: outputs clear without a clock edge
    bus.i_op = 3'd0; bus.i_word = 1'b0; bus.i_src1 = 64'd11; bus.i_src2 = 64'd13; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.o_valid, 0);
    chk("arst_busy",  bus.o_busy,  0);
    chk("arst_res",   bus.o_res,   0);
    chk("arst_ready", bus.o_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'd5, 0, 64'd100, 64'd7, 0, got, lat);
    chk("after_rst_divu", got, 64'd14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/exu_muldiv_seq.md
Name: exu_muldiv_seq

Overview:
- Multi-cycle sequencer and iterative datapath for RV64M multiply/divide ops, sitting beside the single-cycle EXU ALU.
- IDU dispatches M-extension ops here instead of the ALU. The block accepts one op via valid/ready, iterates one bit per cycle, applies the sign fix-up, and holds the result until the LSU/WBU side takes it.
- While busy it stalls the front end by deasserting o_ready.

Parameters:
- XLEN, 64, operand/result width (equals CPU_WIDTH).
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  op request valid.
- o_ready  output  1  block can accept an op.
- i_op  input  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=DIV 5=DIVU 6=REM 7=REMU.
- i_word  input  1  RV64 *W variant (MULW/DIVW/DIVUW/REMW/REMUW).
- i_src1  input  XLEN  rs1 data.
- i_src2  input  XLEN  rs2 data.
- i_flush  input  1  abort the current op (redirect/trap).
- o_valid  output  1  result valid.
- i_ready  input  1  consumer takes the result.
- o_res  output  XLEN  result.
- o_busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; o_valid=0; o_res=0; o_busy=0; counter=0; all operand/partial registers=0. o_ready=1 once rst deasserts.
- o_ready is 1 only in IDLE. Accept = i_valid & o_ready at a rising edge; operands, op and word are latched on that edge.
- States: IDLE, BUSY, FIX, DONE.
  - IDLE -> DONE on accept of a special-case divide.
  - IDLE -> BUSY on any other accept.
  - BUSY -> FIX when counter reaches N-1.
  - FIX -> DONE unconditionally.
  - DONE -> IDLE when i_ready=1.
- Iteration count N = 32 if i_word else XLEN. Counter increments once per BUSY cycle.
- Operand prep at accept:
  - i_word: low 32 bits are used. Sign-extended for MUL/DIV/REM, zero-extended for DIVU/REMU.
  - Signed ops use magnitudes: MULH both operands signed; MULHSU only src1 signed; DIV/REM both signed. Result sign is recorded at accept.
- Multiply: shift-add, one multiplier bit per cycle, 2N-bit product register.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Sign negation of the 2N-bit product happens in FIX.
- Divide: restoring division, one quotient bit per cycle.
  - FIX negates the quotient if the operand signs differ (signed ops).
  - FIX negates the remainder if the dividend is negative (signed ops).
- Word results: bit 31 sign-extended to XLEN for all i_word ops.
- i_word with op 1,2,3 is treated as MUL (MULW).
- Latency:
  - Normal op: o_valid rises exactly N+1 cycles after the accept edge (65 for XLEN ops, 33 for W ops).
  - Special-case op: o_valid rises 1 cycle after accept.
- Special cases (decided at accept, no iteration):
  - Divide by zero: quotient = all ones (W: 0xFFFFFFFF sign-extended to XLEN); remainder = dividend (W: sign-extended low 32 bits).
  - Signed overflow (dividend = most-negative, divisor = -1, for XLEN or W width): quotient = dividend; remainder = 0.
- Output hold: o_valid and o_res stay stable in DONE until i_ready=1. o_valid drops the cycle after the handshake.
- Back-to-back: the next op is accepted no earlier than the cycle after DONE exits (no accept in DONE).
- Flush:
  - i_flush=1 in any state forces IDLE next cycle and clears o_valid.
  - i_flush has priority over accept and over the DONE handshake; a result present in DONE is discarded.
  - o_res keeps its last value (don't-care while o_valid=0).
- i_valid while not ready: ignored; the requester must hold the op.
- Reset mid-op: immediate return to reset values; no result emitted.

Test Plan:
- MUL 7*(-3), i_word=0 -> o_valid 65 cycles after accept, o_res=0xFFFFFFFFFFFFFFEB; o_ready=0 throughout.
- MULHU 0xFFFFFFFFFFFFFFFF*0xFFFFFFFFFFFFFFFF -> o_res=0xFFFFFFFFFFFFFFFE. MULH -1*-1 -> 0. MULHSU -1*2 -> 0xFFFFFFFFFFFFFFFF.
- DIV -20/3 -> quotient 0xFFFFFFFFFFFFFFFA. REM -20/3 -> 0xFFFFFFFFFFFFFFFE. DIVUW 0x00000000FFFFFFFF/2 -> 0x000000007FFFFFFF, latency 33.
- Special cases, each with o_valid 1 cycle after accept:
  - DIV x/0 -> all ones; REMU 5/0 -> 5.
  - DIV 0x8000000000000000/-1 -> 0x8000000000000000; REM same operands -> 0.
  - DIVW 0x80000000/-1 -> 0xFFFFFFFF80000000.
- Hold and backpressure: i_ready=0 for 10 cycles in DONE -> o_valid and o_res stable. i_ready=1 -> o_valid=0 and o_ready=1 next cycle. New op accepted the following cycle yields the correct result.
- Flush and reset:
  - i_flush at BUSY cycle 20 -> IDLE next cycle, no o_valid. The subsequent MUL 3*4 returns 12.
  - Async rst pulse mid-BUSY -> outputs at reset values without waiting for a clock edge.
